// File: rtl/bus_rr_scheduler.sv
// Round-robin scheduler that moves packets from DRVRS driver FIFOs across one shared bus.
// Define BUS_SCHED_BCAST_EN to deliver BROADCAST packets to every driver except the source.
module bus_rr_scheduler #(
  parameter int          DRVRS     = 4,
  parameter int          PKG_SIZE  = 16,
  parameter logic [7:0]  BROADCAST = 8'hFF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [DRVRS-1:0]          pndng,
  input  logic [DRVRS*PKG_SIZE-1:0] d_pop,
  output logic [DRVRS-1:0]          pop,
  output logic [DRVRS-1:0]          push,
  output logic [PKG_SIZE-1:0]       d_push,
  output logic [3:0]                grant_id,
  output logic                      busy,
  output logic                      err
);

  typedef enum logic [1:0] {IDLE, POP, ROUTE, PUSH} state_t;

  state_t              state;
  state_t              next_state;
  logic [3:0]          last_grant;
  logic [3:0]          pick;
  logic                any_pndng;
  logic                pend_sel;
  logic [PKG_SIZE-1:0] head_pkt;
  logic [PKG_SIZE-1:0] pkt;
  logic [7:0]          dest;
  logic                route_ok;
  logic [DRVRS-1:0]    route_mask;
  logic [DRVRS-1:0]    push_mask;

  assign any_pndng = |pndng;
  assign dest      = pkt[PKG_SIZE-1 -: 8];

  // Scan downward so the lowest offset after last_grant is the one left standing.
  always_comb begin
    pick = grant_id;
    for (int k = DRVRS; k >= 1; k--) begin
      for (int i = 0; i < DRVRS; i++) begin
        if (pndng[i] && (i == (int'(last_grant) + k) % DRVRS)) begin
          pick = 4'(i);
        end
      end
    end
  end

  always_comb begin
    pend_sel = 1'b0;
    head_pkt = '0;
    for (int i = 0; i < DRVRS; i++) begin
      if (4'(i) == grant_id) begin
        pend_sel = pndng[i];
        head_pkt = d_pop[i*PKG_SIZE +: PKG_SIZE];
      end
    end
  end

  always_comb begin
    route_ok   = 1'b0;
    route_mask = '0;
    if ((int'(dest) < DRVRS) && (dest != {4'd0, grant_id})) begin
      route_ok = 1'b1;
      for (int i = 0; i < DRVRS; i++) begin
        route_mask[i] = (8'(i) == dest);
      end
    end
`ifdef BUS_SCHED_BCAST_EN
    else if (dest == BROADCAST) begin
      route_ok = 1'b1;
      for (int i = 0; i < DRVRS; i++) begin
        route_mask[i] = (4'(i) != grant_id);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Strobes are decoded from the state so an asynchronous reset clears them at once.
  always_comb begin
    next_state = state;
    pop        = '0;
    push       = '0;
    err        = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (any_pndng) begin
          next_state = POP;
        end
      end
      POP: begin
        if (pend_sel) begin
          for (int i = 0; i < DRVRS; i++) begin
            pop[i] = (4'(i) == grant_id);
          end
          next_state = ROUTE;
        end else begin
          next_state = IDLE;
        end
      end
      ROUTE: begin
        if (route_ok) begin
          next_state = PUSH;
        end else begin
          err        = 1'b1;
          next_state = IDLE;
        end
      end
      PUSH: begin
        push       = push_mask;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // last_grant only moves once a packet is delivered or dropped, never on a withdrawn request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_id   <= 4'd0;
      last_grant <= 4'(DRVRS - 1);
      pkt        <= '0;
      push_mask  <= '0;
      d_push     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_pndng) begin
            grant_id <= pick;
          end
        end
        POP: begin
          if (pend_sel) begin
            pkt <= head_pkt;
          end
        end
        ROUTE: begin
          if (route_ok) begin
            push_mask <= route_mask;
            d_push    <= pkt;
          end else begin
            last_grant <= grant_id;
          end
        end
        PUSH: begin
          last_grant <= grant_id;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Scoreboard bench for bus_rr_scheduler: stimulus queues expected pop/push/err events,
// a negedge monitor pops and compares them, including the cycle each one must appear in.
module tb_bus_rr_scheduler;

  localparam int DRVRS    = 4;
  localparam int PKG_SIZE = 16;

  logic                      clk   = 1'b0;
  logic                      reset = 1'b0;
  logic [DRVRS-1:0]          pndng;
  logic [DRVRS*PKG_SIZE-1:0] d_pop;
  logic [DRVRS-1:0]          pop;
  logic [DRVRS-1:0]          push;
  logic [PKG_SIZE-1:0]       d_push;
  logic [3:0]                grant_id;
  logic                      busy;
  logic                      err;

  logic [15:0] mem [DRVRS][8];
  int          wr_ptr [DRVRS];
  int          rd_ptr [DRVRS];
  logic [3:0]  hide = '0;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  typedef struct {int kind; logic [3:0] mask; logic [15:0] data; int at;} ev_t;
  typedef struct {string name; logic [31:0] act; logic [31:0] exp;} chk_t;
  ev_t  sb[$];
  chk_t dq[$];

  bus_rr_scheduler #(.DRVRS(DRVRS), .PKG_SIZE(PKG_SIZE), .BROADCAST(8'hFF)) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .d_pop(d_pop), .pop(pop), .push(push),
    .d_push(d_push), .grant_id(grant_id), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Driver FIFO model: the head leaves on the edge that closes a pop cycle.
  always @(posedge clk) begin
    for (int i = 0; i < DRVRS; i++) begin
      if (pop[i]) rd_ptr[i] <= rd_ptr[i] + 1;
    end
  end

  always_comb begin
    pndng = '0;
    d_pop = '0;
    for (int i = 0; i < DRVRS; i++) begin
      pndng[i] = (wr_ptr[i] != rd_ptr[i]) && !hide[i];
      d_pop[i*PKG_SIZE +: PKG_SIZE] = mem[i][rd_ptr[i] % 8];
    end
  end

  task automatic observe(input int kind, input logic [3:0] m, input logic [15:0] d);
    ev_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("[TB] FAIL unexpected_event: got kind=%0d mask=%b data=%h cyc=%0d, required no event",
               kind, m, d, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.mask != m || e.data != d || e.at != cyc) begin
        bad++;
        $display("[TB] FAIL event: got kind=%0d mask=%b data=%h cyc=%0d, required kind=%0d mask=%b data=%h cyc=%0d",
                 kind, m, d, cyc, e.kind, e.mask, e.data, e.at);
      end
    end
  endtask

  // Monitor: kind 0 = pop, 1 = push, 2 = err.
  always @(negedge clk) begin
    while (dq.size() != 0) begin
      chk_t c;
      c = dq.pop_front();
      total++;
      if (c.act !== c.exp) begin
        bad++;
        $display("[TB] FAIL %s: got %h, required %h", c.name, c.act, c.exp);
      end
    end
    if (reset) begin
      if (pop != '0) observe(0, pop, 16'h0);
      if (push != '0) observe(1, push, d_push);
      if (err) observe(2, 4'b0000, 16'h0);
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    dq.push_back('{name, act, exp});
  endtask

  task automatic load(input int drv, input logic [15:0] p);
    mem[drv][wr_ptr[drv] % 8] = p;
    wr_ptr[drv] = wr_ptr[drv] + 1;
  endtask

  task automatic expect_ev(input int kind, input logic [3:0] m, input logic [15:0] d, input int at);
    sb.push_back('{kind, m, d, at});
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output(name, 32'(sb.size() != 0), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin : apply_stimulus
    int c0;
    int c1;
    repeat (2) @(negedge clk);
    check_output("reset_strobes", 32'({pop, push, err, busy}), 32'd0);
    check_output("reset_grant", 32'(grant_id), 32'd0);
    check_output("reset_dpush", 32'(d_push), 32'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // All four pending from reset: order 0,1,2,3,0, one pop every four cycles.
    c0 = cyc;
    load(0, 16'h0111); load(1, 16'h0222); load(2, 16'h0333); load(3, 16'h0044); load(0, 16'h0355);
    expect_ev(0, 4'b0001, 16'h0,    c0 + 1);  expect_ev(1, 4'b0010, 16'h0111, c0 + 3);
    expect_ev(0, 4'b0010, 16'h0,    c0 + 5);  expect_ev(1, 4'b0100, 16'h0222, c0 + 7);
    expect_ev(0, 4'b0100, 16'h0,    c0 + 9);  expect_ev(1, 4'b1000, 16'h0333, c0 + 11);
    expect_ev(0, 4'b1000, 16'h0,    c0 + 13); expect_ev(1, 4'b0001, 16'h0044, c0 + 15);
    expect_ev(0, 4'b0001, 16'h0,    c0 + 17); expect_ev(1, 4'b1000, 16'h0355, c0 + 19);
    wait_drain("drain_all_pending", 40);

    c0 = cyc;
    load(0, 16'h02AA);
    expect_ev(0, 4'b0001, 16'h0, c0 + 1);
    expect_ev(1, 4'b0100, 16'h02AA, c0 + 3);
    wait_drain("drain_single", 20);
    check_output("d_push_hold", 32'({push, d_push}), 32'({4'b0000, 16'h02AA}));

    // Source 1 addresses itself, then an out-of-range destination; 2 follows each time.
    c0 = cyc;
    load(1, 16'h0112); load(2, 16'h0323);
    expect_ev(0, 4'b0010, 16'h0, c0 + 1);
    expect_ev(2, 4'b0000, 16'h0, c0 + 2);
    expect_ev(0, 4'b0100, 16'h0, c0 + 4);
    expect_ev(1, 4'b1000, 16'h0323, c0 + 6);
    wait_drain("drain_self_dest", 20);
    c0 = cyc;
    load(1, 16'h07AB); load(2, 16'h0120);
    expect_ev(0, 4'b0010, 16'h0, c0 + 1);
    expect_ev(2, 4'b0000, 16'h0, c0 + 2);
    expect_ev(0, 4'b0100, 16'h0, c0 + 4);
    expect_ev(1, 4'b0010, 16'h0120, c0 + 6);
    wait_drain("drain_range_dest", 20);

    c0 = cyc;
    load(2, 16'hFF55);
    expect_ev(0, 4'b0100, 16'h0, c0 + 1);
`ifdef BUS_SCHED_BCAST_EN
    expect_ev(1, 4'b1011, 16'hFF55, c0 + 3);
`else
    expect_ev(2, 4'b0000, 16'h0, c0 + 2);
`endif
    wait_drain("drain_broadcast", 20);

    // Driver 3 withdraws while in POP; it must keep priority over driver 0 afterwards.
    load(3, 16'h0166);
    @(posedge clk);
    #1 hide = 4'b1000;
    @(negedge clk);
    check_output("busy_in_pop", 32'({busy, pop}), 32'({1'b1, 4'b0000}));
    repeat (2) @(negedge clk);
    check_output("idle_after_withdraw", 32'(busy), 32'd0);
    c1 = cyc;
    hide = 4'b0000;
    load(0, 16'h0277);
    expect_ev(0, 4'b1000, 16'h0, c1 + 1);
    expect_ev(1, 4'b0010, 16'h0166, c1 + 3);
    expect_ev(0, 4'b0001, 16'h0, c1 + 5);
    expect_ev(1, 4'b0100, 16'h0277, c1 + 7);
    wait_drain("drain_regrant", 30);

    c0 = cyc;
    load(1, 16'h0299);
    expect_ev(0, 4'b0010, 16'h0, c0 + 1);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check_output("abort_strobes", 32'({pop, push, err, busy}), 32'd0);
    check_output("abort_dpush", 32'(d_push), 32'd0);
    check_output("abort_grant", 32'(grant_id), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    c1 = cyc;
    load(2, 16'h0311);
    expect_ev(0, 4'b0100, 16'h0, c1 + 1);
    expect_ev(1, 4'b1000, 16'h0311, c1 + 3);
    wait_drain("drain_after_reset", 20);

    check_output("final_idle", 32'(busy), 32'd0);
    check_output("scoreboard_empty", 32'(sb.size()), 32'd0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
